// File: rtl/buf_chain_pipe.sv
// Elastic chain of DEPTH register stages with per-stage optional inversion.
// Each stage hands its word forward when the next stage can take it; a full chain still moves when the output pops.
module buf_chain_pipe #(
   parameter int               WIDTH    = 1,
   parameter int               DEPTH    = 2,
   parameter logic [DEPTH-1:0] INV_MASK = {DEPTH{1'b1}}
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       in_valid,
   input  logic [WIDTH-1:0]           in_data,
   output logic                       in_ready,
   input  logic                       inv_en,
   output logic                       out_valid,
   output logic [WIDTH-1:0]           out_data,
   input  logic                       out_ready,
   output logic [$clog2(DEPTH+1)-1:0] occupancy
);

   localparam int OCC_W = $clog2(DEPTH+1);

   logic [DEPTH-1:0]            valid_q;
   logic [DEPTH-1:0][WIDTH-1:0] data_q;
   logic [OCC_W-1:0]            occ_q;

   logic [DEPTH:0]              ready;
   logic [DEPTH-1:0]            src_valid;
   logic [DEPTH-1:0][WIDTH-1:0] src_data;
   logic [DEPTH-1:0]            load;
   logic [DEPTH-1:0]            drain;
   logic [DEPTH-1:0]            inv;
   logic                        push;
   logic                        pop;

   // Stage k can accept when any stage from k to the end has a hole or the sink pops.
   // Written flat rather than as a ripple so no bit of ready feeds another.
   always_comb begin
      ready = '0;
      for (int k = 0; k <= DEPTH; k++) begin
         ready[k] = out_ready;
         for (int j = k; j < DEPTH; j++) begin
            if (!valid_q[j]) begin
               ready[k] = 1'b1;
            end
         end
      end
   end

   if (DEPTH == 1) begin : g_src_single
      assign src_valid = in_valid;
      assign src_data  = in_data;
   end else begin : g_src_chain
      assign src_valid = {valid_q[DEPTH-2:0], in_valid};
      assign src_data  = {data_q[DEPTH-2:0], in_data};
   end

   assign load  = ready[DEPTH-1:0] & src_valid;
   assign drain = ready[DEPTH:1] & valid_q;
   assign inv   = INV_MASK & {DEPTH{inv_en}};
   assign push  = in_valid & ready[0];
   assign pop   = valid_q[DEPTH-1] & out_ready;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         valid_q <= '0;
         data_q  <= '0;
      end else begin
         for (int k = 0; k < DEPTH; k++) begin
            if (load[k]) begin
               valid_q[k] <= 1'b1;
               data_q[k]  <= src_data[k] ^ {WIDTH{inv[k]}};
            end else if (drain[k]) begin
               valid_q[k] <= 1'b0;
            end
         end
      end
   end

   // Occupancy tracks accepted-minus-popped words; a simultaneous push and pop leaves it unchanged.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         occ_q <= '0;
      end else if (push && !pop) begin
         occ_q <= occ_q + OCC_W'(1);
      end else if (pop && !push) begin
         occ_q <= occ_q - OCC_W'(1);
      end
   end

   // in_ready is held high while in reset; the reset branch above blocks any load.
   assign in_ready  = ready[0] | ~rst_n;
   assign out_valid = valid_q[DEPTH-1];
   assign out_data  = data_q[DEPTH-1];
   assign occupancy = occ_q;

endmodule

// File: tb/tb_buf_chain_pipe.sv
// Directed bench for buf_chain_pipe: several parameterisations side by side plus a scoreboarded random run.
module tb_buf_chain_pipe;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int compared   = 0;
   int mismatched = 0;

   logic rst_n;
   logic d_rst_n;

   logic       a_in_valid, a_in_ready, a_inv_en, a_out_valid, a_out_ready;
   logic [7:0] a_in_data, a_out_data;
   logic [1:0] a_occ;

   logic       b_in_valid, b_in_ready, b_inv_en, b_out_valid, b_out_ready;
   logic [7:0] b_in_data, b_out_data;
   logic [1:0] b_occ;

   logic       c_in_valid, c_in_ready, c_inv_en, c_out_valid, c_out_ready;
   logic [7:0] c_in_data, c_out_data;
   logic [2:0] c_occ;

   logic       d_in_valid, d_in_ready, d_inv_en, d_out_valid, d_out_ready;
   logic [7:0] d_in_data, d_out_data;
   logic [1:0] d_occ;

   logic       e_in_valid, e_in_ready, e_inv_en, e_out_valid, e_out_ready;
   logic [0:0] e_in_data, e_out_data;
   logic [0:0] e_occ;

   buf_chain_pipe #(.WIDTH(8), .DEPTH(2), .INV_MASK(2'b11)) u_a (
      .clk(clk), .rst_n(rst_n), .in_valid(a_in_valid), .in_data(a_in_data), .in_ready(a_in_ready),
      .inv_en(a_inv_en), .out_valid(a_out_valid), .out_data(a_out_data), .out_ready(a_out_ready),
      .occupancy(a_occ));

   buf_chain_pipe #(.WIDTH(8), .DEPTH(3), .INV_MASK(3'b001)) u_b (
      .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_data(b_in_data), .in_ready(b_in_ready),
      .inv_en(b_inv_en), .out_valid(b_out_valid), .out_data(b_out_data), .out_ready(b_out_ready),
      .occupancy(b_occ));

   buf_chain_pipe #(.WIDTH(8), .DEPTH(4), .INV_MASK(4'b0111)) u_c (
      .clk(clk), .rst_n(rst_n), .in_valid(c_in_valid), .in_data(c_in_data), .in_ready(c_in_ready),
      .inv_en(c_inv_en), .out_valid(c_out_valid), .out_data(c_out_data), .out_ready(c_out_ready),
      .occupancy(c_occ));

   buf_chain_pipe #(.WIDTH(8), .DEPTH(3), .INV_MASK(3'b111)) u_d (
      .clk(clk), .rst_n(d_rst_n), .in_valid(d_in_valid), .in_data(d_in_data), .in_ready(d_in_ready),
      .inv_en(d_inv_en), .out_valid(d_out_valid), .out_data(d_out_data), .out_ready(d_out_ready),
      .occupancy(d_occ));

   buf_chain_pipe #(.WIDTH(1), .DEPTH(1), .INV_MASK(1'b1)) u_e (
      .clk(clk), .rst_n(rst_n), .in_valid(e_in_valid), .in_data(e_in_data), .in_ready(e_in_ready),
      .inv_en(e_inv_en), .out_valid(e_out_valid), .out_data(e_out_data), .out_ready(e_out_ready),
      .occupancy(e_occ));

   logic [7:0] sb[$];
   int         cnt = 0;
   logic [7:0] exp8;
   logic [7:0] w [5];

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      compared++;
      if (observed !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, observed, expected, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   // One scoreboarded cycle on the DEPTH=4 instance; its three inverting stages complement each word.
   task automatic applyStimulus(input logic iv, input logic ordy, input logic [7:0] din);
      logic exp_rdy;
      logic [7:0] e;
      c_in_valid  = iv;
      c_out_ready = ordy;
      c_in_data   = din;
      #1;
      exp_rdy = (cnt < 4) || ordy;
      checkOutput("t34_in_ready", 32'(c_in_ready), 32'(exp_rdy));
      if (c_out_valid && ordy) begin
         if (sb.size() == 0) begin
            checkOutput("t34_sb_nonempty", 32'(sb.size()), 32'd1);
         end else begin
            e = sb.pop_front();
            checkOutput("t34_data", 32'(c_out_data), 32'(e));
            cnt--;
         end
      end
      if (iv && exp_rdy) begin
         e = ~din;
         sb.push_back(e);
         cnt++;
      end
      step();
      checkOutput("t34_occ", 32'(c_occ), 32'(cnt));
   endtask

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      rst_n = 1'b0; d_rst_n = 1'b0;
      {a_in_valid, a_inv_en, a_out_ready, a_in_data} = '0;
      {b_in_valid, b_inv_en, b_out_ready, b_in_data} = '0;
      {c_in_valid, c_inv_en, c_out_ready, c_in_data} = '0;
      {d_in_valid, d_inv_en, d_out_ready, d_in_data} = '0;
      {e_in_valid, e_inv_en, e_out_ready, e_in_data} = '0;
      w[0] = 8'h11; w[1] = 8'h22; w[2] = 8'h33; w[3] = 8'h44; w[4] = 8'h55;
      @(negedge clk);
      step();
      checkOutput("rst_out_valid", 32'(a_out_valid), 32'd0);
      checkOutput("rst_in_ready", 32'(a_in_ready), 32'd1);
      checkOutput("rst_out_data", 32'(a_out_data), 32'd0);
      checkOutput("rst_occ", 32'(a_occ), 32'd0);
      checkOutput("rst_c_in_ready", 32'(c_in_ready), 32'd1);
      rst_n = 1'b1; d_rst_n = 1'b1;

      // DEPTH=2, both stages invert: the word comes out unchanged two edges later.
      a_in_valid = 1'b1; a_in_data = 8'hA5; a_inv_en = 1'b1; a_out_ready = 1'b1;
      step();
      a_in_valid = 1'b0;
      checkOutput("t31_lat1_valid", 32'(a_out_valid), 32'd0);
      checkOutput("t31_lat1_occ", 32'(a_occ), 32'd1);
      step();
      checkOutput("t31_valid", 32'(a_out_valid), 32'd1);
      checkOutput("t31_data", 32'(a_out_data), 32'hA5);
      step();
      checkOutput("t31_popped", 32'(a_out_valid), 32'd0);
      checkOutput("t31_occ0", 32'(a_occ), 32'd0);

      // DEPTH=3, only stage 0 inverts; repeated with the inversion disabled.
      b_out_ready = 1'b1;
      for (int r = 0; r < 2; r++) begin
         b_inv_en = (r == 0);
         b_in_valid = 1'b1; b_in_data = 8'h0F;
         step();
         b_in_data = 8'h10;
         step();
         b_in_valid = 1'b0;
         checkOutput("t32_lat_valid", 32'(b_out_valid), 32'd0);
         step();
         checkOutput("t32_w0_valid", 32'(b_out_valid), 32'd1);
         checkOutput("t32_w0_data", 32'(b_out_data), (r == 0) ? 32'hF0 : 32'h0F);
         step();
         checkOutput("t32_w1_valid", 32'(b_out_valid), 32'd1);
         checkOutput("t32_w1_data", 32'(b_out_data), (r == 0) ? 32'hEF : 32'h10);
         step();
         checkOutput("t32_empty", 32'(b_out_valid), 32'd0);
      end

      // DEPTH=4 fills under backpressure, then pushes and pops on the same edge.
      c_inv_en = 1'b1; c_out_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         c_in_valid = 1'b1; c_in_data = w[i];
         #1;
         checkOutput("t33_fill_ready", 32'(c_in_ready), 32'd1);
         step();
      end
      c_in_data = w[4];
      #1;
      exp8 = ~w[0];
      checkOutput("t33_full_ready", 32'(c_in_ready), 32'd0);
      checkOutput("t33_full_occ", 32'(c_occ), 32'd4);
      checkOutput("t33_full_valid", 32'(c_out_valid), 32'd1);
      checkOutput("t33_full_data", 32'(c_out_data), 32'(exp8));
      step();
      checkOutput("t33_hold_data", 32'(c_out_data), 32'(exp8));
      checkOutput("t33_hold_occ", 32'(c_occ), 32'd4);
      checkOutput("t33_hold_ready", 32'(c_in_ready), 32'd0);
      c_out_ready = 1'b1;
      #1;
      checkOutput("t33_pass_ready", 32'(c_in_ready), 32'd1);
      step();
      c_in_valid = 1'b0;
      exp8 = ~w[1];
      checkOutput("t33_swap_occ", 32'(c_occ), 32'd4);
      checkOutput("t33_swap_data", 32'(c_out_data), 32'(exp8));
      for (int i = 2; i < 5; i++) begin
         step();
         exp8 = ~w[i];
         checkOutput("t33_drain_valid", 32'(c_out_valid), 32'd1);
         checkOutput("t33_drain_data", 32'(c_out_data), 32'(exp8));
         checkOutput("t33_drain_occ", 32'(c_occ), 32'(5 - i));
      end
      step();
      checkOutput("t33_empty_valid", 32'(c_out_valid), 32'd0);
      checkOutput("t33_empty_occ", 32'(c_occ), 32'd0);

      for (int cyc = 0; cyc < 10000; cyc++) begin
         applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom));
      end
      for (int i = 0; i < 8; i++) begin
         applyStimulus(1'b0, 1'b1, 8'h00);
      end
      checkOutput("t34_drained_valid", 32'(c_out_valid), 32'd0);
      checkOutput("t34_drained_sb", 32'(sb.size()), 32'd0);

      // Reset mid-operation discards the held words; a fresh word takes three edges.
      d_inv_en = 1'b1; d_out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         d_in_valid = 1'b1; d_in_data = w[i];
         step();
      end
      d_in_valid = 1'b0;
      checkOutput("t35_full_occ", 32'(d_occ), 32'd3);
      d_rst_n = 1'b0;
      step();
      checkOutput("t35_rst_valid", 32'(d_out_valid), 32'd0);
      checkOutput("t35_rst_occ", 32'(d_occ), 32'd0);
      checkOutput("t35_rst_data", 32'(d_out_data), 32'd0);
      checkOutput("t35_rst_ready", 32'(d_in_ready), 32'd1);
      d_rst_n = 1'b1;
      d_in_valid = 1'b1; d_in_data = 8'h3C;
      step();
      d_in_valid = 1'b0; d_out_ready = 1'b1;
      checkOutput("t35_lat1", 32'(d_out_valid), 32'd0);
      step();
      checkOutput("t35_lat2", 32'(d_out_valid), 32'd0);
      step();
      checkOutput("t35_lat3_valid", 32'(d_out_valid), 32'd1);
      checkOutput("t35_lat3_data", 32'(d_out_data), 32'hC3);

      // DEPTH=1 single elastic register with an inverting stage.
      e_inv_en = 1'b1; e_out_ready = 1'b0; e_in_valid = 1'b1; e_in_data = 1'b1;
      #1;
      checkOutput("t36_ready0", 32'(e_in_ready), 32'd1);
      step();
      e_in_valid = 1'b0;
      checkOutput("t36_valid", 32'(e_out_valid), 32'd1);
      checkOutput("t36_data", 32'(e_out_data), 32'd0);
      checkOutput("t36_stall_ready", 32'(e_in_ready), 32'd0);
      checkOutput("t36_occ", 32'(e_occ), 32'd1);
      step();
      checkOutput("t36_hold_data", 32'(e_out_data), 32'd0);
      checkOutput("t36_hold_ready", 32'(e_in_ready), 32'd0);
      e_out_ready = 1'b1;
      #1;
      checkOutput("t36_release_ready", 32'(e_in_ready), 32'd1);
      step();
      checkOutput("t36_empty", 32'(e_out_valid), 32'd0);
      checkOutput("t36_empty_occ", 32'(e_occ), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
